// File: rtl/csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// csr_access_ctrl
//
// Sequences Zicsr accesses (CSRRW/CSRRS/CSRRC and their immediate forms) from
// the execute stage into the machine-mode CSR bank. Each access is taken in
// IDLE, decoded for a full cycle, optionally written for one cycle, and then
// answered over a valid/ready response channel.
//
// Ports
//   CLK, RST      : clock; synchronous active-high reset
//   req_valid     : request strobe from execute
//   req_ready     : high only in IDLE; request accepted on valid & ready
//   req_op        : 01=RW, 10=RS, 11=RC, 00=reserved (illegal)
//   req_addr      : 12-bit CSR address
//   req_wdata     : rs1 value or zero-extended uimm
//   req_src_zero  : rs1==x0 / uimm==0 (RS/RC then become pure reads)
//   req_priv      : current privilege (11=M, 01=S, 00=U)
//   csr_rdata     : flattened bank outputs, slice 0 = misa ... slice 7 = mip
//   csr_en        : one-hot write enable, same slice order, WRITE cycle only
//   csr_d         : write data to the selected register, 0 outside WRITE
//   resp_valid    : response valid (RESP state)
//   resp_ready    : response consumed
//   resp_rdata    : CSR value seen in DECODE (0 when illegal)
//   resp_illegal  : illegal-instruction flag
// ---------------------------------------------------------------------------
module csr_access_ctrl #(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] WMASK_MSTATUS = 'h0000_1888,
  parameter logic [XLEN-1:0] WMASK_MIE     = 'h0000_0888,
  parameter logic [XLEN-1:0] WMASK_MIP     = 'h0000_0000,
  parameter logic [XLEN-1:0] WMASK_MISA    = 'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [11:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic              req_src_zero,
  input  logic [1:0]        req_priv,
  input  logic [8*XLEN-1:0] csr_rdata,
  output logic [7:0]        csr_en,
  output logic [XLEN-1:0]   csr_d,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_illegal
);

  localparam int unsigned N_CSR = 8;

  localparam logic [1:0] OP_RSV = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  // Bank slice indices (order of csr_rdata / csr_en)
  localparam logic [2:0] IDX_MISA      = 3'd0;
  localparam logic [2:0] IDX_MVENDORID = 3'd1;
  localparam logic [2:0] IDX_MARCHID   = 3'd2;
  localparam logic [2:0] IDX_MIMPID    = 3'd3;
  localparam logic [2:0] IDX_MHARTID   = 3'd4;
  localparam logic [2:0] IDX_MSTATUS   = 3'd5;
  localparam logic [2:0] IDX_MIE       = 3'd6;
  localparam logic [2:0] IDX_MIP       = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured request
  logic [1:0]      r_op;
  logic [11:0]     r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_src_zero;
  logic [1:0]      r_priv;

  // Values carried from DECODE into WRITE/RESP
  logic [XLEN-1:0] r_old;
  logic [2:0]      r_sel;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_illegal;

  // Decode results
  logic [XLEN-1:0] w_csr_arr [N_CSR];
  logic            w_hit;
  logic [2:0]      w_sel;
  logic            w_write_intent;
  logic            w_illegal;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_wmask;
  logic [XLEN-1:0] w_new;

  // Unpack the flattened bank so the selected slice is a simple array index.
  genvar gi;
  generate
    for (gi = 0; gi < N_CSR; gi++) begin : g_unpack
      assign w_csr_arr[gi] = csr_rdata[gi*XLEN +: XLEN];
    end
  endgenerate

  // Address map
  always_comb begin
    w_hit = 1'b1;
    w_sel = IDX_MISA;
    case (r_addr)
      12'h301: w_sel = IDX_MISA;
      12'hF11: w_sel = IDX_MVENDORID;
      12'hF12: w_sel = IDX_MARCHID;
      12'hF13: w_sel = IDX_MIMPID;
      12'hF14: w_sel = IDX_MHARTID;
      12'h300: w_sel = IDX_MSTATUS;
      12'h304: w_sel = IDX_MIE;
      12'h344: w_sel = IDX_MIP;
      default: w_hit = 1'b0;
    endcase
  end

  // RS/RC with a zero source never write; RW always writes, even with x0.
  assign w_write_intent = (r_op == OP_RW) || !r_src_zero;

  // addr[9:8] encodes the lowest privilege allowed to touch the CSR and
  // addr[11:10]==11 marks the read-only space.
  assign w_illegal = (r_op == OP_RSV)
                  || !w_hit
                  || (r_priv < r_addr[9:8])
                  || (w_write_intent && (r_addr[11:10] == 2'b11));

  assign w_old = w_csr_arr[w_sel];

  // WARL masks for the register selected in DECODE. The ID registers are
  // read-only and never reach WRITE, so they carry an all-zero mask.
  always_comb begin
    w_wmask = '0;
    case (r_sel)
      IDX_MISA:    w_wmask = WMASK_MISA;
      IDX_MSTATUS: w_wmask = WMASK_MSTATUS;
      IDX_MIE:     w_wmask = WMASK_MIE;
      IDX_MIP:     w_wmask = WMASK_MIP;
      default:     w_wmask = '0;
    endcase
  end

  // Unmasked new value; the reserved op never reaches WRITE.
  always_comb begin
    w_new = r_old;
    case (r_op)
      OP_RW:   w_new = r_wdata;
      OP_RS:   w_new = r_old | r_wdata;
      OP_RC:   w_new = r_old & ~r_wdata;
      default: w_new = r_old;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= ST_IDLE;
      r_op           <= OP_RSV;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_src_zero     <= 1'b0;
      r_priv         <= 2'b00;
      r_old          <= '0;
      r_sel          <= '0;
      r_resp_rdata   <= '0;
      r_resp_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op       <= req_op;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_src_zero <= req_src_zero;
            r_priv     <= req_priv;
          end
        end
        ST_DECODE: begin
          // The response always reports the pre-write value.
          r_old <= w_old;
          r_sel <= w_sel;
          if (w_illegal) begin
            r_resp_rdata   <= '0;
            r_resp_illegal <= 1'b1;
          end else begin
            r_resp_rdata   <= w_old;
            r_resp_illegal <= 1'b0;
          end
        end
        ST_RESP: begin
          // Return the response outputs to zero once consumed.
          if (resp_ready) begin
            r_resp_rdata   <= '0;
            r_resp_illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (!w_illegal && w_write_intent) w_state_next = ST_WRITE;
        else                              w_state_next = ST_RESP;
      end
      ST_WRITE: begin
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready    = (r_state == ST_IDLE);
    resp_valid   = (r_state == ST_RESP);
    resp_rdata   = r_resp_rdata;
    resp_illegal = r_resp_illegal;
    csr_en       = '0;
    csr_d        = '0;
    if (r_state == ST_WRITE) begin
      csr_en[r_sel] = 1'b1;
      csr_d         = (r_old & ~w_wmask) | (w_new & w_wmask);
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_access_ctrl
//
// Directed bench for csr_access_ctrl. A small register bank model answers
// csr_rdata and absorbs csr_en/csr_d writes; every expected value below is
// worked out by hand from the CSR map and WARL masks.
// ---------------------------------------------------------------------------
module tb_csr_access_ctrl;

  localparam int XLEN = 32;

  logic              CLK;
  logic              RST;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [11:0]       req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              req_src_zero;
  logic [1:0]        req_priv;
  logic [8*XLEN-1:0] csr_rdata;
  logic [7:0]        csr_en;
  logic [XLEN-1:0]   csr_d;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] bank [8];

  csr_access_ctrl #(.XLEN(XLEN)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_src_zero (req_src_zero),
    .req_priv     (req_priv),
    .csr_rdata    (csr_rdata),
    .csr_en       (csr_en),
    .csr_d        (csr_d),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register bank: misa, mvendorid, marchid, mimpid, mhartid, mstatus, mie, mip
  always @(posedge CLK) begin
    if (RST) begin
      bank[0] <= 32'h4000_1100;
      bank[1] <= 32'h0000_0000;
      bank[2] <= 32'h0000_0000;
      bank[3] <= 32'h0000_0000;
      bank[4] <= 32'h0000_0000;
      bank[5] <= 32'h0000_0000;
      bank[6] <= 32'h0000_0008;
      bank[7] <= 32'h0000_0080;
    end else begin
      for (int i = 0; i < 8; i++)
        if (csr_en[i]) bank[i] <= csr_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    for (int i = 0; i < 8; i++) csr_rdata[i*32 +: 32] = bank[i];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  // Issues one request (entered at posedge+1), measures accept->resp_valid
  // latency, records csr_en activity and completes the response handshake.
  // lat stays -1 if no response arrives within the cycle budget.
  task automatic run_access(input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] wd, input logic sz,
                            input logic [1:0] pv,
                            output int lat, output int en_pulses,
                            output logic [7:0] en_val, output logic [31:0] d_val,
                            output logic [31:0] rd, output logic ill);
    int waitc;
    req_op = op; req_addr = addr; req_wdata = wd;
    req_src_zero = sz; req_priv = pv; req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(posedge CLK); #1; waitc++;
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    lat = -1; en_pulses = 0; en_val = '0; d_val = '0;
    for (int c = 1; c <= 20; c++) begin
      if (csr_en != 8'h00) begin
        en_pulses++; en_val = csr_en; d_val = csr_d;
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(posedge CLK); #1;
    end
    rd  = resp_rdata;
    ill = resp_illegal;
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    $display("access op=%b addr=%h wdata=%h sz=%b priv=%b -> lat=%0d en=%b d=%h rdata=%h ill=%b",
             op, addr, wd, sz, pv, lat, en_val, d_val, rd, ill);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++;
    if (csr_en !== 8'h00) begin errors++; $display("FAIL reset_csr_en: got %b expected 00000000", csr_en); end
    checks++;
    if (csr_d !== 32'h0) begin errors++; $display("FAIL reset_csr_d: got %h expected 00000000", csr_d); end
    checks++;
    if (resp_rdata !== 32'h0 || resp_illegal !== 1'b0) begin
      errors++; $display("FAIL reset_resp: got rdata=%h ill=%b expected 00000000/0", resp_rdata, resp_illegal);
    end
    $display("reset: req_ready=%b resp_valid=%b csr_en=%b", req_ready, resp_valid, csr_en);
  endtask

  task automatic test_mstatus_rw();
    int lat, np; logic [7:0] en; logic [31:0] d, rd; logic ill;
    run_access(2'b01, 12'h300, 32'hFFFF_FFFF, 1'b0, 2'b11, lat, np, en, d, rd, ill);
    checks++; if (lat != 3) begin errors++; $display("FAIL mstatus_rw_latency: got %0d expected 3", lat); end
    checks++; if (np != 1 || en !== 8'b0010_0000) begin errors++; $display("FAIL mstatus_rw_en: got %b x%0d expected 00100000 x1", en, np); end
    checks++; if (d !== 32'h0000_1888) begin errors++; $display("FAIL mstatus_rw_d: got %h expected 00001888", d); end
    checks++; if (rd !== 32'h0 || ill !== 1'b0) begin errors++; $display("FAIL mstatus_rw_resp: got %h/%b expected 00000000/0", rd, ill); end
  endtask

  task automatic test_mie_rs_rc();
    int lat, np; logic [7:0] en; logic [31:0] d, rd; logic ill;
    run_access(2'b10, 12'h304, 32'h0000_0080, 1'b0, 2'b11, lat, np, en, d, rd, ill);
    checks++; if (lat != 3 || np != 1 || en !== 8'b0100_0000) begin errors++; $display("FAIL mie_rs_en: got lat=%0d en=%b x%0d expected 3/01000000 x1", lat, en, np); end
    checks++; if (d !== 32'h0000_0088) begin errors++; $display("FAIL mie_rs_d: got %h expected 00000088", d); end
    checks++; if (rd !== 32'h0000_0008 || ill !== 1'b0) begin errors++; $display("FAIL mie_rs_resp: got %h/%b expected 00000008/0", rd, ill); end
    run_access(2'b11, 12'h304, 32'h0000_0008, 1'b0, 2'b11, lat, np, en, d, rd, ill);
    checks++; if (lat != 3 || np != 1 || en !== 8'b0100_0000) begin errors++; $display("FAIL mie_rc_en: got lat=%0d en=%b x%0d expected 3/01000000 x1", lat, en, np); end
    checks++; if (d !== 32'h0000_0080) begin errors++; $display("FAIL mie_rc_d: got %h expected 00000080", d); end
    checks++; if (rd !== 32'h0000_0088 || ill !== 1'b0) begin errors++; $display("FAIL mie_rc_resp: got %h/%b expected 00000088/0", rd, ill); end
  endtask

  task automatic test_readonly();
    int lat, np; logic [7:0] en; logic [31:0] d, rd; logic ill;
    run_access(2'b01, 12'hF14, 32'h0000_0005, 1'b0, 2'b11, lat, np, en, d, rd, ill);
    checks++; if (ill !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ro_write_illegal: got %h/%b expected 00000000/1", rd, ill); end
    checks++; if (np != 0 || lat != 2) begin errors++; $display("FAIL ro_write_noen: got pulses=%0d lat=%0d expected 0/2", np, lat); end
    run_access(2'b10, 12'hF14, 32'h0000_0000, 1'b1, 2'b11, lat, np, en, d, rd, ill);
    checks++; if (ill !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL ro_read_legal: got %h/%b expected 00000000/0", rd, ill); end
    checks++; if (np != 0 || lat != 2) begin errors++; $display("FAIL ro_read_lat: got pulses=%0d lat=%0d expected 0/2", np, lat); end
    run_access(2'b11, 12'h301, 32'h0000_0000, 1'b1, 2'b11, lat, np, en, d, rd, ill);
    checks++; if (ill !== 1'b0 || rd !== 32'h4000_1100 || np != 0 || lat != 2) begin
      errors++; $display("FAIL misa_read: got %h/%b pulses=%0d lat=%0d expected 40001100/0/0/2", rd, ill, np, lat);
    end
  endtask

  task automatic test_illegal();
    logic [1:0]  ops   [3] = '{2'b10, 2'b10, 2'b00};
    logic [11:0] addrs [3] = '{12'h300, 12'h7C0, 12'h300};
    logic [1:0]  privs [3] = '{2'b00, 2'b11, 2'b11};
    logic        szs   [3] = '{1'b0, 1'b1, 1'b0};
    int lat, np; logic [7:0] en; logic [31:0] d, rd; logic ill;
    for (int k = 0; k < 3; k++) begin
      run_access(ops[k], addrs[k], 32'h0000_0008, szs[k], privs[k], lat, np, en, d, rd, ill);
      checks++;
      if (ill !== 1'b1 || rd !== 32'h0 || np != 0 || lat != 2) begin
        errors++; $display("FAIL illegal_%0d: got ill=%b rdata=%h pulses=%0d lat=%0d expected 1/00000000/0/2", k, ill, rd, np, lat);
      end
    end
  endtask

  task automatic test_warl();
    int lat, np; logic [7:0] en; logic [31:0] d, rd; logic ill;
    run_access(2'b01, 12'h301, 32'h0000_0000, 1'b0, 2'b11, lat, np, en, d, rd, ill);
    checks++; if (en !== 8'b0000_0001 || d !== 32'h4000_1100 || rd !== 32'h4000_1100 || ill !== 1'b0) begin
      errors++; $display("FAIL misa_warl: got en=%b d=%h rdata=%h ill=%b expected 00000001/40001100/40001100/0", en, d, rd, ill);
    end
    run_access(2'b01, 12'h344, 32'hFFFF_FFFF, 1'b0, 2'b11, lat, np, en, d, rd, ill);
    checks++; if (en !== 8'b1000_0000 || d !== 32'h0000_0080 || rd !== 32'h0000_0080 || lat != 3) begin
      errors++; $display("FAIL mip_warl: got en=%b d=%h rdata=%h lat=%0d expected 10000000/00000080/00000080/3", en, d, rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    // Read mie (now 0x80), stall the response, queue a read of mip meanwhile.
    req_op = 2'b10; req_addr = 12'h304; req_wdata = '0; req_src_zero = 1'b1;
    req_priv = 2'b11; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_addr = 12'h344;
    @(posedge CLK); #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0080 || resp_illegal !== 1'b0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_%0d: got valid=%b rdata=%h ill=%b req_ready=%b expected 1/00000080/0/0",
                           c, resp_valid, resp_rdata, resp_illegal, req_ready);
      end
      @(posedge CLK); #1;
    end
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got req_ready=%b resp_valid=%b expected 1/0", req_ready, resp_valid);
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: got req_ready=%b expected 0", req_ready); end
    @(posedge CLK); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0080 || resp_illegal !== 1'b0) begin
      errors++; $display("FAIL b2b_resp: got valid=%b rdata=%h ill=%b expected 1/00000080/0", resp_valid, resp_rdata, resp_illegal);
    end
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    $display("back_to_back: stalled mie read then queued mip read completed");
  endtask

  task automatic test_reset_abort();
    req_op = 2'b01; req_addr = 12'h300; req_wdata = 32'h0000_0008;
    req_src_zero = 1'b0; req_priv = 2'b11; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (csr_en !== 8'b0010_0000) begin errors++; $display("FAIL abort_write_en: got %b expected 00100000", csr_en); end
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (csr_en !== 8'h00 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_reset: got en=%b req_ready=%b resp_valid=%b expected 00000000/1/0", csr_en, req_ready, resp_valid);
    end
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (csr_en !== 8'h00 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL abort_quiet_%0d: got en=%b resp_valid=%b expected 00000000/0", c, csr_en, resp_valid);
      end
    end
    $display("reset_abort: en=%b req_ready=%b", csr_en, req_ready);
  endtask

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0;
    req_wdata = '0; req_src_zero = 1'b0; req_priv = 2'b11; resp_ready = 1'b0;
    test_reset();
    test_mstatus_rw();
    test_mie_rs_rc();
    test_readonly();
    test_illegal();
    test_warl();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
